// File: rtl/serializer_if.sv
// Handshake and serial-link signals of the serializer: queue side (data/valid/ack)
// and receiver side (bit, strobe, ready), plus status and done flags.
interface serializer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ack_out;
  logic                  rx_ready_in;
  logic                  data_out;
  logic                  write_out;
  logic                  status_out;
  logic                  done_out;

  modport master (
    output data_in, valid_in, rx_ready_in,
    input  ack_out, data_out, write_out, status_out, done_out
  );

  modport slave (
    input  data_in, valid_in, rx_ready_in,
    output ack_out, data_out, write_out, status_out, done_out
  );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: captures one word on valid/ack, then emits it one bit
// per write_out strobe while the receiver is ready, with optional idle gap between bits.
module serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input logic        clock_100KHZ,
  input logic        reset,
  serializer_if.slave bus
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            gap_q, gap_d;
  logic                  data_q, data_d;
  logic                  write_q, write_d;
  logic                  ack_q, ack_d;
  logic                  done_q, done_d;
  logic                  status_q, status_d;
  logic                  head;
  logic                  send_bit;

  assign head     = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
  assign send_bit = (state_q == SEND) && bus.rx_ready_in && (gap_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    write_d  = 1'b0;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    status_d = 1'b0;

    // Gap keeps draining in every state so the spacing also holds across word boundaries.
    if (send_bit) begin
      gap_d = 4'(GAP_CYCLES);
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end else begin
      gap_d = gap_q;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          shreg_d = bus.data_in;
          cnt_d   = CW'(DATA_WIDTH);
          ack_d   = 1'b1;
          state_d = SEND;
        end else begin
          status_d = 1'b1;
        end
      end
      SEND: begin
        if (send_bit) begin
          write_d = 1'b1;
          data_d  = head;
          shreg_d = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[DATA_WIDTH-1:1]};
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_100KHZ or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      data_q   <= 1'b0;
      write_q  <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      write_q  <= write_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.write_out  = write_q;
  assign bus.ack_out    = ack_q;
  assign bus.done_out   = done_q;
  assign bus.status_out = status_q;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: three instances (MSB-first, LSB-first, GAP_CYCLES=2),
// expected serial bits queued at word launch and popped on every write_out strobe.
module tb_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] din    [3];
  logic       valid  [3];
  logic       rdy    [3];
  logic       wr     [3];
  logic       dout   [3];
  logic       ack    [3];
  logic       done   [3];
  logic       status [3];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    serializer_if #(.DATA_WIDTH(8)) bus ();
    assign bus.data_in     = din[g];
    assign bus.valid_in    = valid[g];
    assign bus.rx_ready_in = rdy[g];
    assign wr[g]     = bus.write_out;
    assign dout[g]   = bus.data_out;
    assign ack[g]    = bus.ack_out;
    assign done[g]   = bus.done_out;
    assign status[g] = bus.status_out;

    serializer #(
      .DATA_WIDTH(8),
      .MSB_FIRST (g != 1),
      .GAP_CYCLES((g == 2) ? 2 : 0)
    ) u_dut (
      .clock_100KHZ(clk),
      .reset       (rst_n),
      .bus         (bus)
    );
  end

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  bit exp_q[$];
  int pulse_t[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gap_of(input int i);
    return (i == 2) ? 2 : 0;
  endfunction

  // Launch one word on instance i and follow it to done; optional receiver stall after a bit.
  task automatic run_word(input int i, input logic [7:0] w, input int stall_after,
                          input int stall_len);
    logic [7:0] t;
    int done_t;
    int stall_left;
    int extra_acks;
    t = w;
    for (int b = 0; b < 8; b++) begin
      if (i != 1) begin
        exp_q.push_back(t[7]);
        t = t << 1;
      end else begin
        exp_q.push_back(t[0]);
        t = t >> 1;
      end
    end
    pulse_t.delete();
    done_t     = -1;
    stall_left = 0;
    extra_acks = 0;
    din[i]   = w;
    valid[i] = 1'b1;
    rdy[i]   = 1'b1;
    tick();
    chk1("ack_pulse", ack[i], 1'b1);
    chk1("status_busy", status[i], 1'b0);
    valid[i] = 1'b0;
    for (int c = 1; c <= 200 && done_t < 0; c++) begin
      rdy[i] = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      tick();
      if (ack[i]) extra_acks++;
      if (wr[i]) begin
        chk1("exclusive_strobes", ack[i] | done[i], 1'b0);
        if (exp_q.size() == 0) chkn("extra_bit", pulse_t.size() + 1, 8);
        else chk1("serial_bit", dout[i], exp_q.pop_front());
        pulse_t.push_back(c);
        if (pulse_t.size() == stall_after && stall_len > 0) stall_left = stall_len;
      end
      if (done[i]) done_t = c;
    end
    rdy[i] = 1'b1;
    chkn("single_ack", extra_acks, 0);
    chkn("pulse_count", pulse_t.size(), 8);
    chk1("done_seen", done_t >= 0, 1'b1);
    if (pulse_t.size() == 8) begin
      chkn("first_bit_latency", pulse_t[0], 1);
      for (int k = 1; k < 8; k++)
        chkn("bit_spacing", pulse_t[k] - pulse_t[k-1],
             (k == stall_after && stall_len > 0) ? stall_len + 1 : 1 + gap_of(i));
      chkn("done_latency", done_t, pulse_t[7] + 1);
    end
    chk1("status_during_done", status[i], 1'b0);
    tick();
    chk1("status_back_idle", status[i], 1'b1);
    exp_q.delete();
  endtask

  // Two words with valid held high; a behavioural receiver reassembles them.
  task automatic run_stream();
    logic [7:0] words[$];
    logic [7:0] rx;
    int acks;
    int nb;
    int got;
    int last_wr;
    int ack_t;
    words   = '{8'h5A, 8'hC3};
    rx      = '0;
    acks    = 0;
    nb      = 0;
    got     = 0;
    last_wr = -1;
    ack_t   = -1;
    din[0]   = 8'h5A;
    valid[0] = 1'b1;
    rdy[0]   = 1'b1;
    for (int c = 0; c < 300 && got < 2; c++) begin
      tick();
      if (ack[0]) begin
        acks++;
        ack_t = c;
        if (last_wr >= 0) chkn("last_bit_to_ack", c - last_wr, 2);
        if (acks == 1) din[0] = 8'hC3;
        if (acks >= 2) valid[0] = 1'b0;
      end
      if (wr[0]) begin
        if (nb == 0) chkn("ack_to_first_bit", c - ack_t, 1);
        rx = {rx[6:0], dout[0]};
        nb++;
        last_wr = c;
        if (nb == 8) begin
          chk8("rx_word", rx, words.pop_front());
          nb = 0;
          got++;
        end
      end
    end
    chkn("words_received", got, 2);
    valid[0] = 1'b0;
    repeat (15) begin
      tick();
      if (ack[0]) acks++;
    end
    chkn("ack_total", acks, 2);
  endtask

  initial begin
    int n;
    int done_cnt;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[i]   = '0;
      valid[i] = 1'b0;
      rdy[i]   = 1'b1;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk1("rst_status", status[i], 1'b0);
      chk1("rst_write", wr[i], 1'b0);
      chk1("rst_ack", ack[i], 1'b0);
      chk1("rst_done", done[i], 1'b0);
      chk1("rst_data", dout[i], 1'b0);
    end
    rst_n = 1'b1;
    chk1("status_before_edge", status[0], 1'b0);
    tick();
    for (int i = 0; i < 3; i++) chk1("status_after_release", status[i], 1'b1);

    run_word(0, 8'hA5, 0, 0);
    run_word(1, 8'h01, 0, 0);
    run_word(2, 8'hFF, 0, 0);
    if (pulse_t.size() == 8) chkn("gap_span", pulse_t[7] - pulse_t[0], 21);
    run_word(0, 8'h3C, 3, 5);
    run_stream();

    // Reset in the middle of a word.
    din[0]   = 8'hF0;
    valid[0] = 1'b1;
    rdy[0]   = 1'b1;
    tick();
    chk1("mid_ack", ack[0], 1'b1);
    valid[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      tick();
      if (wr[0]) n++;
    end
    chkn("bits_before_reset", n, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_data", dout[0], 1'b0);
    chk1("async_rst_write", wr[0], 1'b0);
    chk1("async_rst_ack", ack[0], 1'b0);
    chk1("async_rst_done", done[0], 1'b0);
    chk1("async_rst_status", status[0], 1'b0);
    done_cnt = 0;
    repeat (3) begin
      tick();
      if (done[0]) done_cnt++;
    end
    rst_n = 1'b1;
    chk1("status_held_low", status[0], 1'b0);
    tick();
    if (done[0]) done_cnt++;
    chkn("no_done_after_abort", done_cnt, 0);
    chk1("status_after_mid_reset", status[0], 1'b1);
    run_word(0, 8'h0F, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
